uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional odd/even parity, one or two
// stop bits, and a valid/ready output register carrying per-frame error flags.
module uart_rx_cfg #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;

  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [CW-1:0] CYCLE_LAST = CW'(CYCLE - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

  generate
    if (CYCLE < 4) begin : g_cycle_chk
      $error("uart_rx_cfg: CLK_FRE/BAUD_RATE gives fewer than 4 clocks per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_chk
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   shift, shift_n;
  logic                   par_pend, par_pend_n;
  logic                   frm_pend, frm_pend_n;
  logic                   frame_done;
  logic                   rx_meta, rx_sync, rx_prev;
  logic                   fall;
  logic                   tick;
  logic                   exp_par;

  // Synchronizer and edge history all reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall    = rx_prev & ~rx_sync;
  assign tick    = (cnt == CYCLE_LAST);
  assign exp_par = (PARITY == 1) ? ~(^shift) : (^shift);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_pend <= par_pend_n;
      frm_pend <= frm_pend_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_pend_n = par_pend;
    frm_pend_n = frm_pend;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (fall) begin
          state_n    = ST_START;
          par_pend_n = 1'b0;
          frm_pend_n = 1'b0;
        end
      end
      // A line that is high again at mid start bit was only a glitch.
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_n      = '0;
          par_pend_n = (rx_sync != exp_par);
          state_n    = ST_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      // Leave straight after the last stop sample so the next start edge is caught early.
      ST_STOP: begin
        if (tick) begin
          cnt_n = '0;
          if (!rx_sync) frm_pend_n = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n  = '0;
            state_n    = ST_IDLE;
            frame_done = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output holding register: a completing frame loads only if the slot is free or draining now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (frame_done && (!rx_data_valid || rx_data_ready)) begin
        rx_data       <= shift;
        parity_err    <= par_pend;
        frame_err     <= frm_pend_n;
        rx_data_valid <= 1'b1;
      end else begin
        if (frame_done) overrun_err <= 1'b1;
        if (rx_data_valid && rx_data_ready) begin
          rx_data_valid <= 1'b0;
          parity_err    <= 1'b0;
          frame_err     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations driven with directed and random frames and
// checked every cycle against a frame-level queue model of what the receiver must deliver.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxd;
  logic [2:0] rdy;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [8:0] d2;
  logic [2:0] vld, perr, ferr, ovr, bsy;

  always #5 clk = ~clk;

  uart_rx_cfg u0 (
    .clk(clk), .rst_n(rst_n), .rx_rxd(rxd[0]), .rx_data(d0), .rx_data_valid(vld[0]),
    .rx_data_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun_err(ovr[0]), .busy(bsy[0])
  );

  uart_rx_cfg #(.CLK_FRE(50), .BAUD_RATE(2500000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_rxd(rxd[1]), .rx_data(d1), .rx_data_valid(vld[1]),
    .rx_data_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun_err(ovr[1]), .busy(bsy[1])
  );

  uart_rx_cfg #(.CLK_FRE(50), .BAUD_RATE(3125000), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_rxd(rxd[2]), .rx_data(d2), .rx_data_valid(vld[2]),
    .rx_data_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun_err(ovr[2]), .busy(bsy[2])
  );

  typedef struct {
    int         id;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc_cnt = 0;
  int         rmode[3];
  int         valid_cnt[3];
  int         busy_cnt[3];
  int         ovr_cnt[3];
  int         rise_cyc[3];
  int         last_start[3];
  logic       prev_vld[3];
  logic [8:0] last_data[3];
  logic       last_perr[3];
  logic       last_ferr[3];

  function automatic int cycle_of(input int id);
    case (id)
      0:       return 50000000 / 115200;
      1:       return 50000000 / 2500000;
      default: return 50000000 / 3125000;
    endcase
  endfunction

  function automatic int nbits_of(input int id);
    case (id)
      0:       return 8;
      1:       return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int par_of(input int id);
    case (id)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int stop_of(input int id);
    return (id == 1) ? 2 : 1;
  endfunction

  // Parity bit a correct transmitter sends: even makes the total count of ones even.
  function automatic logic good_parity(input int id, input logic [8:0] data);
    int ones;
    ones = $countones(data);
    return (par_of(id) == 2) ? logic'(ones % 2) : logic'(1 - (ones % 2));
  endfunction

  // Clocks from start edge to valid: (1 + data + parity + stop - 0.5) bit times plus 3.
  function automatic int lat_lo(input int id);
    int nb;
    nb = 1 + nbits_of(id) + ((par_of(id) != 0) ? 1 : 0) + stop_of(id);
    return ((2 * nb - 1) * cycle_of(id)) / 2 + 3;
  endfunction

  function automatic logic [8:0] dout(input int id);
    case (id)
      0:       return {1'b0, d0};
      1:       return {2'b0, d1};
      default: return d2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame on rxd[id]; keep=0 means the model expects the receiver to drop it.
  task automatic applyStimulus(input int id, input logic [8:0] data, input bit flip,
                               input logic [1:0] stops, input bit keep);
    int         cyc;
    int         nb;
    logic [8:0] dm;
    logic       pb;
    exp_t       e;
    cyc = cycle_of(id);
    nb  = nbits_of(id);
    dm  = data & 9'((1 << nb) - 1);
    pb  = good_parity(id, dm) ^ flip;
    if (keep) begin
      e.id   = id;
      e.data = dm;
      e.perr = (par_of(id) != 0) && (pb != good_parity(id, dm));
      e.ferr = (stops[0] == 1'b0) || (stop_of(id) == 2 && stops[1] == 1'b0);
      q.push_back(e);
    end
    last_start[id] = cyc_cnt;
    rxd[id] = 1'b0;
    waitCycles(cyc);
    for (int b = 0; b < nb; b++) begin
      rxd[id] = dm[b];
      waitCycles(cyc);
    end
    if (par_of(id) != 0) begin
      rxd[id] = pb;
      waitCycles(cyc);
    end
    for (int s = 0; s < stop_of(id); s++) begin
      rxd[id] = stops[s];
      waitCycles(cyc);
    end
    rxd[id] = 1'b1;
  endtask

  task automatic waitDrain(input int limit);
    int k;
    k = 0;
    while (q.size() != 0 && k < limit) begin
      waitCycles(1);
      k++;
    end
    checkOutput("queue_drained", 32'(q.size()), 32'd0);
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      rdy[i] = (rmode[i] == 2) ? 1'($urandom_range(0, 1)) : (rmode[i] == 1);
  end

  // Every cycle: a valid output must match the oldest expected frame for that receiver.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 3; i++) begin
        if (vld[i]) begin
          valid_cnt[i]++;
          if (!prev_vld[i]) rise_cyc[i] = cyc_cnt;
          if (q.size() == 0 || q[0].id != i) begin
            checkOutput($sformatf("unexpected_valid_dut%0d", i), 32'(vld[i]), 32'd0);
          end else begin
            checkOutput($sformatf("frame_dut%0d", i), {21'd0, dout(i), perr[i], ferr[i]},
                        {21'd0, q[0].data, q[0].perr, q[0].ferr});
            if (rdy[i]) begin
              last_data[i] = dout(i);
              last_perr[i] = perr[i];
              last_ferr[i] = ferr[i];
              void'(q.pop_front());
            end
          end
        end else if (perr[i] || ferr[i]) begin
          checkOutput($sformatf("flags_without_valid_dut%0d", i), {30'd0, perr[i], ferr[i]}, 32'd0);
        end
        if (bsy[i]) busy_cnt[i]++;
        if (ovr[i]) ovr_cnt[i]++;
        prev_vld[i] = vld[i];
      end
    end
  end

  initial begin
    #960000;
    bad++;
    $display("[TB] FAIL watchdog: cycle budget exhausted at cycle %0d", cyc_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int v0, b0, o0, o1, o2;
    logic [8:0] rd;
    for (int i = 0; i < 3; i++) begin
      rmode[i] = 1; valid_cnt[i] = 0; busy_cnt[i] = 0; ovr_cnt[i] = 0;
      rise_cyc[i] = 0; last_start[i] = 0; prev_vld[i] = 1'b0;
      last_data[i] = '0; last_perr[i] = 1'b0; last_ferr[i] = 1'b0;
    end
    rst_n = 1'b0;
    rxd   = 3'b111;
    waitCycles(3);
    checkOutput("reset_data", {24'd0, d0}, 32'd0);
    checkOutput("reset_valid", {29'd0, vld}, 32'd0);
    checkOutput("reset_perr", {29'd0, perr}, 32'd0);
    checkOutput("reset_ferr", {29'd0, ferr}, 32'd0);
    checkOutput("reset_ovr", {29'd0, ovr}, 32'd0);
    checkOutput("reset_busy", {29'd0, bsy}, 32'd0);
    rst_n = 1'b1;
    waitCycles(5);

    $display("[TB] 8N1 frame 0xA5 with ready held high");
    v0 = valid_cnt[0];
    o0 = ovr_cnt[0];
    applyStimulus(0, 9'hA5, 1'b0, 2'b11, 1'b1);
    waitCycles(20);
    checkOutput("a5_data", {23'd0, last_data[0]}, 32'h0A5);
    checkOutput("a5_flags", {30'd0, last_perr[0], last_ferr[0]}, 32'd0);
    checkOutput("a5_valid_cycles", 32'(valid_cnt[0] - v0), 32'd1);
    checkOutput("a5_overrun", 32'(ovr_cnt[0] - o0), 32'd0);
    if (rise_cyc[0] - last_start[0] == lat_lo(0) + 1)
      checkOutput("a5_latency", 32'(rise_cyc[0] - last_start[0]), 32'(lat_lo(0) + 1));
    else
      checkOutput("a5_latency", 32'(rise_cyc[0] - last_start[0]), 32'd4126);

    $display("[TB] framing error on 0x3C then clean 0x3C");
    applyStimulus(0, 9'h3C, 1'b0, 2'b10, 1'b1);
    waitCycles(cycle_of(0));
    checkOutput("ferr_data", {23'd0, last_data[0]}, 32'h03C);
    checkOutput("ferr_flag", {31'd0, last_ferr[0]}, 32'd1);
    applyStimulus(0, 9'h3C, 1'b0, 2'b11, 1'b1);
    waitCycles(20);
    checkOutput("ferr_clean", {31'd0, last_ferr[0]}, 32'd0);

    $display("[TB] 100-clock glitch");
    b0 = busy_cnt[0];
    v0 = valid_cnt[0];
    rxd[0] = 1'b0;
    waitCycles(100);
    rxd[0] = 1'b1;
    waitCycles(400);
    checkOutput("glitch_busy_cycles", 32'(busy_cnt[0] - b0), 32'd217);
    checkOutput("glitch_no_valid", 32'(valid_cnt[0] - v0), 32'd0);
    checkOutput("glitch_idle", {31'd0, bsy[0]}, 32'd0);

    $display("[TB] overrun with ready held low");
    rmode[0] = 0;
    waitCycles(2);
    o0 = ovr_cnt[0];
    applyStimulus(0, 9'h11, 1'b0, 2'b11, 1'b1);
    applyStimulus(0, 9'h22, 1'b0, 2'b11, 1'b0);
    waitCycles(10);
    checkOutput("overrun_pulses", 32'(ovr_cnt[0] - o0), 32'd1);
    checkOutput("overrun_held_valid", {31'd0, vld[0]}, 32'd1);
    checkOutput("overrun_held_data", {24'd0, d0}, 32'h11);
    rmode[0] = 1;
    waitCycles(3);
    checkOutput("overrun_drained_valid", {31'd0, vld[0]}, 32'd0);
    checkOutput("overrun_accepted", {23'd0, last_data[0]}, 32'h011);
    checkOutput("overrun_queue", 32'(q.size()), 32'd0);

    $display("[TB] reset pulse during data bit 3 of 0xFF");
    fork
      applyStimulus(0, 9'hFF, 1'b0, 2'b11, 1'b0);
      begin
        waitCycles(4 * cycle_of(0) + 200);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", {29'd0, bsy}, 32'd0);
        checkOutput("midreset_valid", {29'd0, vld}, 32'd0);
        checkOutput("midreset_data", {24'd0, d0}, 32'd0);
        checkOutput("midreset_flags", {26'd0, perr, ferr}, 32'd0);
        waitCycles(2);
        rst_n = 1'b1;
      end
    join
    waitCycles(cycle_of(0));
    applyStimulus(0, 9'h5A, 1'b0, 2'b11, 1'b1);
    waitCycles(20);
    checkOutput("after_reset_data", {23'd0, last_data[0]}, 32'h05A);
    checkOutput("after_reset_flags", {30'd0, last_perr[0], last_ferr[0]}, 32'd0);

    $display("[TB] 7E2 parity frames");
    applyStimulus(1, 9'h03, 1'b1, 2'b11, 1'b1);
    waitCycles(10);
    checkOutput("par_bad_data", {23'd0, last_data[1]}, 32'h003);
    checkOutput("par_bad_flag", {31'd0, last_perr[1]}, 32'd1);
    applyStimulus(1, 9'h03, 1'b0, 2'b11, 1'b1);
    waitCycles(10);
    checkOutput("par_good_flag", {31'd0, last_perr[1]}, 32'd0);
    checkOutput("u1_latency_low", 32'((rise_cyc[1] - last_start[1]) >= lat_lo(1)), 32'd1);
    checkOutput("u1_latency_high", 32'((rise_cyc[1] - last_start[1]) <= lat_lo(1) + 1), 32'd1);

    $display("[TB] random frames on 7E2 and 9O1 receivers");
    rmode[1] = 2;
    rmode[2] = 2;
    o1 = ovr_cnt[1];
    o2 = ovr_cnt[2];
    for (int n = 0; n < 40; n++) begin
      for (int id = 1; id < 3; id++) begin
        logic [1:0] st;
        st    = 2'b11;
        st[0] = ($urandom_range(0, 3) != 0);
        rd    = 9'($urandom_range(0, 511));
        applyStimulus(id, rd, ($urandom_range(0, 3) == 0), st, 1'b1);
        if (id == 2 && !st[0]) waitCycles(cycle_of(id));
        waitCycles($urandom_range(0, 2) * cycle_of(id) / 2);
      end
    end
    waitDrain(200);
    checkOutput("random_overrun_u1", 32'(ovr_cnt[1] - o1), 32'd0);
    checkOutput("random_overrun_u2", 32'(ovr_cnt[2] - o2), 32'd0);
    rmode[1] = 1;
    rmode[2] = 1;
    waitCycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
